// File: rtl/sm4_encryptor_pkg.sv
// rtl/sm4_encryptor_pkg.sv - SM4 encryptor shared constants and helpers
package sm4_encryptor_pkg;

  localparam int group_size_p      = 128;
  localparam int sm4_word_width_gp = 32;

  function automatic int sm4_words_per_block(input int width);
    return group_size_p / width;
  endfunction

endpackage

// File: rtl/sm4_block_fifo.sv
// rtl/sm4_block_fifo.sv - block-wide FIFO with occupancy and flush
module sm4_block_fifo
  import sm4_encryptor_pkg::*;
#(
  parameter int width_p = group_size_p,
  parameter int els_p   = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [width_p-1:0]         data_i,
  input  logic                       pop_i,
  output logic [width_p-1:0]         data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(els_p+1)-1:0] occupancy_o
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int occ_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem [els_p];
  logic [ptr_w_lp-1:0] wr_ptr, rd_ptr;
  logic [occ_w_lp-1:0] occ;

  function automatic logic [ptr_w_lp-1:0] ptr_next(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign data_o      = mem[rd_ptr];
  assign full_o      = (occ == occ_w_lp'(els_p));
  assign empty_o     = (occ == '0);
  assign occupancy_o = occ;

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_i) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop_i)
        rd_ptr <= ptr_next(rd_ptr);
      case ({push_i, pop_i})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i && !flush_i && pop_i)
      assert (!empty_o);
  end
`endif

endmodule

// File: rtl/sm4_result_serializer.sv
// rtl/sm4_result_serializer.sv - buffers SM4 result blocks and emits them MSW-first as words
module sm4_result_serializer #(
  parameter int group_size_p = sm4_encryptor_pkg::group_size_p,
  parameter int word_width_p = sm4_encryptor_pkg::sm4_word_width_gp,
  parameter int fifo_els_p   = 2
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [group_size_p-1:0]         crypt_i,
  input  logic                            v_i,
  output logic                            yumi_o,
  input  logic                            flush_i,
  output logic [word_width_p-1:0]         data_o,
  output logic                            v_o,
  input  logic                            ready_i,
  output logic                            last_o,
  output logic [$clog2(fifo_els_p+1)-1:0] occupancy_o
);

  localparam int wpb_lp   = group_size_p / word_width_p;
  localparam int cnt_w_lp = (wpb_lp > 1) ? $clog2(wpb_lp) : 1;

  logic                    full, empty, xfer, pop;
  logic [group_size_p-1:0] head;
  logic [cnt_w_lp-1:0]     cnt;
  logic [word_width_p-1:0] words [wpb_lp];

  // Acceptance looks only at stored occupancy, never at ready_i.
  assign yumi_o = v_i & ~full & ~flush_i & ~reset_i;
  assign v_o    = ~empty;
  assign last_o = v_o & (cnt == cnt_w_lp'(wpb_lp - 1));
  assign xfer   = v_o & ready_i;
  assign pop    = xfer & last_o;

  for (genvar k = 0; k < wpb_lp; k++) begin : g_word
    assign words[k] = head[group_size_p-1-k*word_width_p -: word_width_p];
  end

  assign data_o = v_o ? words[cnt] : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i)
      cnt <= '0;
    else if (xfer)
      cnt <= last_o ? '0 : cnt + 1'b1;
  end

  sm4_block_fifo #(
    .width_p (group_size_p),
    .els_p   (fifo_els_p)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .flush_i     (flush_i),
    .push_i      (yumi_o),
    .data_i      (crypt_i),
    .pop_i       (pop),
    .data_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .occupancy_o (occupancy_o)
  );

`ifndef SYNTHESIS
  logic                    hold_r;
  logic [group_size_p-1:0] crypt_r;

  always_ff @(posedge clk_i) begin
    hold_r  <= v_i & ~yumi_o & ~reset_i;
    crypt_r <= crypt_i;
    if (!reset_i) begin
      assert (group_size_p % word_width_p == 0);
      if (hold_r && v_i)
        assert (crypt_i == crypt_r);
    end
  end
`endif

endmodule

// File: tb/tb_sm4_result_serializer.sv
// tb/tb_sm4_result_serializer.sv - self-checking bench for sm4_result_serializer
module tb_sm4_result_serializer;

  logic         clk = 1'b0;
  logic         reset, v_i, flush, ready, yumi, v_o, last;
  logic [127:0] crypt;
  logic [31:0]  data;
  logic [1:0]   occ;

  int checks = 0;
  int errors = 0;

  logic [127:0] mq[$];
  int           mw;
  logic         m_v, m_last, m_yumi, last_yumi;
  logic [31:0]  m_data;
  logic [1:0]   m_occ;

  typedef struct {
    logic         v, rdy;
    logic [127:0] crypt;
    logic         e_yumi, e_v;
    logic [31:0]  e_data;
    logic         e_last;
    logic [1:0]   e_occ;
  } vec_t;

  vec_t tbl[14];

  always #5 clk = ~clk;

  sm4_result_serializer dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .crypt_i     (crypt),
    .v_i         (v_i),
    .yumi_o      (yumi),
    .flush_i     (flush),
    .data_o      (data),
    .v_o         (v_o),
    .ready_i     (ready),
    .last_o      (last),
    .occupancy_o (occ)
  );

  function automatic logic [31:0] word_of(input logic [127:0] b, input int k);
    logic [127:0] s;
    s = b >> (32 * (3 - k));
    return s[31:0];
  endfunction

  function automatic vec_t mk(input logic v, rdy, input logic [127:0] c, input logic ey, ev,
                              input logic [31:0] ed, input logic el, input logic [1:0] eo);
    vec_t r;
    r.v = v; r.rdy = rdy; r.crypt = c; r.e_yumi = ey; r.e_v = ev;
    r.e_data = ed; r.e_last = el; r.e_occ = eo;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic pre(input bit do_chk);
    #4;
    m_v    = (mq.size() != 0);
    m_data = m_v ? word_of(mq[0], mw) : 32'h0;
    m_last = m_v && (mw == 3);
    m_yumi = v_i && (mq.size() < 2) && !flush && !reset;
    m_occ  = 2'(mq.size());
    if (do_chk) begin
      chk("model_yumi", yumi, m_yumi);
      chk("model_v",    v_o,  m_v);
      chk("model_data", data, m_data);
      chk("model_last", last, m_last);
      chk("model_occ",  occ,  m_occ);
    end
  endtask

  task automatic post();
    @(posedge clk);
    if (reset || flush) begin
      mq.delete();
      mw = 0;
    end else begin
      if (m_v && ready) begin
        if (mw == 3) begin
          void'(mq.pop_front());
          mw = 0;
        end else begin
          mw++;
        end
      end
      if (m_yumi) mq.push_back(crypt);
    end
    last_yumi = m_yumi;
    #1;
  endtask

  task automatic cycle();
    pre(1'b1);
    post();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] b, a1, a2, a3, c1, c2;
    int first_yumi;

    b = 128'h681edf34d206965e86b3e94f536e4246;
    mw = 0;
    reset = 1; v_i = 0; flush = 0; ready = 0; crypt = '0;
    @(posedge clk); #1;
    pre(1'b0); post();
    reset = 0;

    // Reset state
    pre(1'b0);
    chk("rst_v", v_o, 1'b0);
    chk("rst_data", data, 32'h0);
    chk("rst_last", last, 1'b0);
    chk("rst_occ", occ, 2'd0);
    chk("rst_yumi", yumi, 1'b0);
    post();

    // Known-vector passthrough then back-pressure over one block
    tbl[0]  = mk(1, 1, b, 1, 0, 32'h0,       0, 0);
    tbl[1]  = mk(0, 1, b, 0, 1, 32'h681edf34, 0, 1);
    tbl[2]  = mk(0, 1, b, 0, 1, 32'hd206965e, 0, 1);
    tbl[3]  = mk(0, 1, b, 0, 1, 32'h86b3e94f, 0, 1);
    tbl[4]  = mk(0, 1, b, 0, 1, 32'h536e4246, 1, 1);
    tbl[5]  = mk(1, 0, b, 1, 0, 32'h0,       0, 0);
    tbl[6]  = mk(0, 1, b, 0, 1, 32'h681edf34, 0, 1);
    tbl[7]  = mk(0, 0, b, 0, 1, 32'hd206965e, 0, 1);
    tbl[8]  = mk(0, 0, b, 0, 1, 32'hd206965e, 0, 1);
    tbl[9]  = mk(0, 1, b, 0, 1, 32'hd206965e, 0, 1);
    tbl[10] = mk(0, 1, b, 0, 1, 32'h86b3e94f, 0, 1);
    tbl[11] = mk(0, 0, b, 0, 1, 32'h536e4246, 1, 1);
    tbl[12] = mk(0, 1, b, 0, 1, 32'h536e4246, 1, 1);
    tbl[13] = mk(0, 1, b, 0, 0, 32'h0,       0, 0);
    for (int i = 0; i < 14; i++) begin
      v_i = tbl[i].v; ready = tbl[i].rdy; crypt = tbl[i].crypt;
      pre(1'b1);
      chk($sformatf("tbl%0d_yumi", i), yumi, tbl[i].e_yumi);
      chk($sformatf("tbl%0d_v", i),    v_o,  tbl[i].e_v);
      chk($sformatf("tbl%0d_data", i), data, tbl[i].e_data);
      chk($sformatf("tbl%0d_last", i), last, tbl[i].e_last);
      chk($sformatf("tbl%0d_occ", i),  occ,  tbl[i].e_occ);
      post();
    end

    // Full FIFO: third block waits until first block fully drains
    a1 = rnd128(); a2 = rnd128(); a3 = rnd128();
    ready = 0; v_i = 1;
    crypt = a1; cycle();
    crypt = a2; cycle();
    crypt = a3;
    pre(1'b1);
    chk("full_yumi", yumi, 1'b0);
    chk("full_occ", occ, 2'd2);
    post();
    ready = 1;
    first_yumi = -1;
    for (int j = 0; j < 20 && first_yumi < 0; j++) begin
      pre(1'b1);
      if (yumi === 1'b1) first_yumi = j;
      post();
    end
    chk("full_accept_cycle", 32'(first_yumi), 32'd4);
    v_i = 0;
    for (int j = 0; j < 9; j++) cycle();
    pre(1'b1);
    chk("full_drained", v_o, 1'b0);
    post();

    // Same-cycle push and pop keeps occupancy
    c1 = rnd128(); c2 = rnd128();
    v_i = 1; crypt = c1; ready = 0; cycle();
    v_i = 0; ready = 1;
    for (int j = 0; j < 3; j++) cycle();
    v_i = 1; crypt = c2;
    pre(1'b1);
    chk("pp_last", last, 1'b1);
    chk("pp_yumi", yumi, 1'b1);
    post();
    v_i = 0;
    pre(1'b1);
    chk("pp_occ", occ, 2'd1);
    chk("pp_word0", data, word_of(c2, 0));
    post();
    for (int j = 0; j < 4; j++) cycle();

    // Flush mid-block with a producer waiting
    c1 = rnd128(); c2 = rnd128();
    v_i = 1; crypt = c1; ready = 1; cycle();
    v_i = 0; cycle(); cycle();
    v_i = 1; crypt = c2; flush = 1;
    pre(1'b1);
    chk("fl_yumi", yumi, 1'b0);
    post();
    flush = 0;
    pre(1'b1);
    chk("fl_v", v_o, 1'b0);
    chk("fl_occ", occ, 2'd0);
    chk("fl_yumi_after", yumi, 1'b1);
    post();
    v_i = 0;
    pre(1'b1);
    chk("fl_word0", data, word_of(c2, 0));
    post();
    for (int j = 0; j < 4; j++) cycle();

    // Reset with two blocks buffered
    ready = 0; v_i = 1;
    crypt = rnd128(); cycle();
    crypt = rnd128(); cycle();
    v_i = 0; reset = 1; cycle();
    reset = 0;
    pre(1'b1);
    chk("rs_v", v_o, 1'b0);
    chk("rs_data", data, 32'h0);
    chk("rs_occ", occ, 2'd0);
    post();
    c1 = rnd128();
    v_i = 1; crypt = c1; cycle();
    v_i = 0; ready = 1;
    pre(1'b1);
    chk("rs_word0", data, word_of(c1, 0));
    post();
    for (int j = 0; j < 4; j++) cycle();

    // Randomized traffic against the queue model
    last_yumi = 0; v_i = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!(v_i && !last_yumi)) begin
        v_i = ($urandom_range(0, 2) != 0);
        crypt = rnd128();
      end
      ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 40) == 0);
      reset = ($urandom_range(0, 150) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
